// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : calc_seq_ctrl                                                 |
// | Desc.    : Button-stepped operand/operation sequencer for a calculator   |
// |            datapath, with press debounce and a two-digit display scan.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module calc_seq_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int SCAN_DIV   = 100
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       op_sw,
  input  logic       btn,
  input  logic       clr,
  input  logic [3:0] res_in,
  input  logic       cy_in,
  output logic [3:0] opa,
  output logic [3:0] opb,
  output logic       op_q,
  output logic [4:0] res_q,
  output logic       res_valid,
  output logic [1:0] state,
  output logic [1:0] disp_src,
  output logic       scan_sel,
  output logic       dis0,
  output logic       dis1
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  localparam logic [7:0]  c_deb_last  = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] c_scan_last = 16'(SCAN_DIV - 1);

  localparam logic [1:0] c_src_sw  = 2'd0;
  localparam logic [1:0] c_src_opa = 2'd1;
  localparam logic [1:0] c_src_res = 2'd2;

  logic [7:0]  r_deb_cnt;
  logic        r_fired;
  logic        w_press;
  logic [15:0] r_scan_cnt;
  logic        r_scan_sel;
  state_t      r_state;
  logic [3:0]  r_opa;
  logic [3:0]  r_opb;
  logic        r_op_q;
  logic [4:0]  r_res_q;
  logic        r_res_valid;
  logic [1:0]  r_disp_src;

  // One pulse per high stretch: r_fired blocks repeats until btn drops.
  assign w_press = btn && !r_fired && (r_deb_cnt >= c_deb_last);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_cnt <= 8'd0;
      r_fired   <= 1'b0;
    end else if (!btn) begin
      r_deb_cnt <= 8'd0;
      r_fired   <= 1'b0;
    end else begin
      if (r_deb_cnt != 8'hFF) begin
        r_deb_cnt <= r_deb_cnt + 8'd1;
      end
      if (w_press) begin
        r_fired <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= 16'd0;
      r_scan_sel <= 1'b0;
    end else if (r_scan_cnt == c_scan_last) begin
      r_scan_cnt <= 16'd0;
      r_scan_sel <= ~r_scan_sel;
    end else begin
      r_scan_cnt <= r_scan_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_A;
      r_opa       <= 4'd0;
      r_opb       <= 4'd0;
      r_op_q      <= 1'b0;
      r_res_q     <= 5'd0;
      r_res_valid <= 1'b0;
      r_disp_src  <= c_src_sw;
    end else if (clr) begin
      r_state     <= S_A;
      r_opa       <= 4'd0;
      r_opb       <= 4'd0;
      r_op_q      <= 1'b0;
      r_res_q     <= 5'd0;
      r_res_valid <= 1'b0;
      r_disp_src  <= c_src_sw;
    end else begin
      case (r_state)
        S_A: begin
          if (w_press) begin
            r_opa      <= sw;
            r_state    <= S_B;
            r_disp_src <= c_src_opa;
          end
        end
        S_B: begin
          if (w_press) begin
            r_opb      <= sw;
            r_op_q     <= op_sw;
            r_state    <= S_EXEC;
            r_disp_src <= c_src_opa;
          end
        end
        S_EXEC: begin
          // Datapath has settled on the operands latched at the previous edge.
          r_res_q     <= {cy_in, res_in};
          r_res_valid <= 1'b1;
          r_state     <= S_SHOW;
          r_disp_src  <= c_src_res;
        end
        default: begin
          if (w_press) begin
            r_res_valid <= 1'b0;
            r_state     <= S_A;
            r_disp_src  <= c_src_sw;
          end
        end
      endcase
    end
  end

  assign opa       = r_opa;
  assign opb       = r_opb;
  assign op_q      = r_op_q;
  assign res_q     = r_res_q;
  assign res_valid = r_res_valid;
  assign state     = r_state;
  assign disp_src  = r_disp_src;
  assign scan_sel  = r_scan_sel;
  assign dis0      = r_scan_sel;
  assign dis1      = ~r_scan_sel;

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_calc_seq_ctrl                                              |
// | Desc.    : Self-checking bench for calc_seq_ctrl with a decimal datapath.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_calc_seq_ctrl;

  localparam int DEB  = 4;
  localparam int SCAN = 4;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       op_sw;
  logic       btn;
  logic       clr;
  logic [3:0] res_in;
  logic       cy_in;
  logic [3:0] opa;
  logic [3:0] opb;
  logic       op_q;
  logic [4:0] res_q;
  logic       res_valid;
  logic [1:0] state;
  logic [1:0] disp_src;
  logic       scan_sel;
  logic       dis0;
  logic       dis1;

  int n_cmp = 0;
  int n_bad = 0;

  calc_seq_ctrl #(.DEB_CYCLES(DEB), .SCAN_DIV(SCAN)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .sw(sw), .op_sw(op_sw), .btn(btn),
    .clr(clr), .res_in(res_in), .cy_in(cy_in), .opa(opa), .opb(opb),
    .op_q(op_q), .res_q(res_q), .res_valid(res_valid), .state(state),
    .disp_src(disp_src), .scan_sel(scan_sel), .dis0(dis0), .dis1(dis1)
  );

  always #5 clk_in = ~clk_in;

  // Decimal add/sub datapath: add carries past 9, subtract gives magnitude + borrow.
  function automatic logic [4:0] dp(input logic [3:0] a, input logic [3:0] b, input logic op);
    int s;
    if (!op) begin
      s = int'(a) + int'(b);
      if (s > 9) return {1'b1, 4'(s - 10)};
      return {1'b0, 4'(s)};
    end
    if (a < b) return {1'b1, 4'(b - a)};
    return {1'b0, 4'(a - b)};
  endfunction

  assign {cy_in, res_in} = dp(opa, opb, op_q);

  int         m_state;
  logic [3:0] m_opa, m_opb;
  logic       m_opq;
  logic [4:0] m_res;
  logic       m_valid;
  int         m_run;
  int         m_scan;

  task automatic model_reset();
    m_state = 0; m_opa = 0; m_opb = 0; m_opq = 0; m_res = 0; m_valid = 0;
    m_run = 0; m_scan = 0;
  endtask

  task automatic model_step();
    bit press;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_scan++;
    press = 1'b0;
    if (btn) begin
      m_run++;
      press = (m_run == DEB);
    end else begin
      m_run = 0;
    end
    if (clr) begin
      m_state = 0; m_opa = 0; m_opb = 0; m_opq = 0; m_res = 0; m_valid = 0;
    end else begin
      case (m_state)
        0: if (press) begin m_opa = sw; m_state = 1; end
        1: if (press) begin m_opb = sw; m_opq = op_sw; m_state = 2; end
        2: begin m_res = dp(m_opa, m_opb, m_opq); m_valid = 1; m_state = 3; end
        default: if (press) begin m_valid = 0; m_state = 0; end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit exp_sel;
    int exp_src;
    exp_sel = ((m_scan / SCAN) % 2) == 1;
    exp_src = (m_state == 0) ? 0 : (m_state == 3) ? 2 : 1;
    check("state", 8'(state), 8'(m_state));
    check("opa", 8'(opa), 8'(m_opa));
    check("opb", 8'(opb), 8'(m_opb));
    check("op_q", 8'(op_q), 8'(m_opq));
    check("res_q", 8'(res_q), 8'(m_res));
    check("res_valid", 8'(res_valid), 8'(m_valid));
    check("disp_src", 8'(disp_src), 8'(exp_src));
    check("scan_sel", 8'(scan_sel), 8'(exp_sel));
    check("dis0", 8'(dis0), 8'(exp_sel));
    check("dis1", 8'(dis1), 8'(!exp_sel));
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    #1;
    check_all();
  endtask

  task automatic press(input int n);
    btn = 1'b1;
    repeat (n) cycle();
    btn = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic [4:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hold;
    vecs[0] = '{a: 4'd7, b: 4'd5, op: 1'b0, exp_res: 5'b10010};
    vecs[1] = '{a: 4'd3, b: 4'd9, op: 1'b1, exp_res: 5'b10110};
    vecs[2] = '{a: 4'd9, b: 4'd3, op: 1'b1, exp_res: 5'b00110};
    vecs[3] = '{a: 4'd4, b: 4'd4, op: 1'b0, exp_res: 5'b01000};
    vecs[4] = '{a: 4'd0, b: 4'd0, op: 1'b0, exp_res: 5'b00000};
    vecs[5] = '{a: 4'd9, b: 4'd9, op: 1'b0, exp_res: 5'b11000};

    rst_n = 1'b0; btn = 1'b0; clr = 1'b0; sw = 4'd0; op_sw = 1'b0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (10) cycle();

    foreach (vecs[i]) begin
      sw = vecs[i].a;
      press(DEB);
      check("vec_to_b", 8'(state), 8'd1);
      sw = vecs[i].b; op_sw = vecs[i].op;
      btn = 1'b1;
      repeat (DEB) cycle();
      check("vec_exec", 8'(state), 8'd2);
      check("vec_valid_low_in_exec", 8'(res_valid), 8'd0);
      btn = 1'b0;
      cycle();
      check("vec_show", 8'(state), 8'd3);
      check("vec_res", 8'(res_q), 8'(vecs[i].exp_res));
      check("vec_valid", 8'(res_valid), 8'd1);
      check("vec_opq", 8'(op_q), 8'(vecs[i].op));
      sw = 4'hF;
      press(DEB);
      check("vec_back_a", 8'(state), 8'd0);
      check("vec_opa_kept", 8'(opa), 8'(vecs[i].a));
      check("vec_opb_kept", 8'(opb), 8'(vecs[i].b));
    end

    // Short hold, long hold, glitch train.
    sw = 4'd2;
    btn = 1'b1; repeat (DEB - 1) cycle(); btn = 1'b0; cycle();
    check("deb_short", 8'(state), 8'd0);
    btn = 1'b1; repeat (20) cycle(); btn = 1'b0; cycle();
    check("deb_long", 8'(state), 8'd1);
    repeat (6) begin btn = 1'b1; cycle(); btn = 1'b0; cycle(); end
    check("deb_glitch", 8'(state), 8'd1);

    // Long hold through S_EXEC must not produce a second step.
    sw = 4'd8;
    btn = 1'b1; repeat (20) cycle(); btn = 1'b0; cycle();
    check("exec_no_queue", 8'(state), 8'd3);
    press(DEB);

    // clr coincident with the press in S_B.
    sw = 4'd6; press(DEB);
    sw = 4'd2;
    btn = 1'b1; repeat (DEB - 1) cycle();
    clr = 1'b1; cycle(); clr = 1'b0; btn = 1'b0;
    check("clr_state", 8'(state), 8'd0);
    check("clr_opa", 8'(opa), 8'd0);
    check("clr_opb", 8'(opb), 8'd0);
    check("clr_res", 8'(res_q), 8'd0);
    cycle();

    // Reset pulse while in S_EXEC.
    sw = 4'd1; press(DEB);
    sw = 4'd9;
    btn = 1'b1; repeat (DEB) cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_state", 8'(state), 8'd0);
    check("rst_async_valid", 8'(res_valid), 8'd0);
    check_all();
    cycle();
    rst_n = 1'b1; btn = 1'b0;
    cycle();
    check("rst_no_capture", 8'(res_valid), 8'd0);

    // Randomized traffic with long button stretches and rare clears.
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        btn  = $urandom_range(0, 1) == 1;
        hold = btn ? $urandom_range(1, 9) : $urandom_range(1, 4);
      end
      hold--;
      sw    = 4'($urandom_range(0, 15));
      op_sw = $urandom_range(0, 1) == 1;
      clr   = $urandom_range(0, 59) == 0;
      cycle();
    end
    btn = 1'b0; clr = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive high cycles on btn before a press is accepted; legal range 1..255.
REQ-002 Parameter SCAN_DIV, default 100: clk_in cycles per display-scan phase; legal range 2..65535.
REQ-003 The block SHALL use one clock, clk_in; reset is asynchronous and active-low, rst_n.
REQ-004 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sw  input  4  operand switches.
REQ-007 op_sw  input  1  operation select: 0 = add, 1 = subtract.
REQ-008 btn  input  1  raw step button, active-high, undebounced.
REQ-009 clr  input  1  synchronous clear, active-high.
REQ-010 res_in  input  4  magnitude result from the add/sub datapath, combinational from opa/opb/op_q.
REQ-011 cy_in  input  1  carry from the datapath.
REQ-012 opa  output  4  registered operand A to the datapath.
REQ-013 opb  output  4  registered operand B to the datapath.
REQ-014 op_q  output  1  registered operation to the datapath.
REQ-015 res_q  output  5  captured result {cy_in, res_in}.
REQ-016 res_valid  output  1  high while res_q holds a result for the current operands.
REQ-017 state  output  2  FSM state: 0 S_A, 1 S_B, 2 S_EXEC, 3 S_SHOW.
REQ-018 disp_src  output  2  display source: 0 = live sw, 1 = opa, 2 = res_q.
REQ-019 scan_sel  output  1  digit phase: 0 = tens, 1 = units.
REQ-020 dis0, dis1  output  1 each  digit enables; dis0 = scan_sel, dis1 = ~scan_sel.

Function
REQ-021 Debounce: a counter SHALL increment while btn = 1 and clear to 0 on any cycle btn = 0.
REQ-022 When that counter reaches DEB_CYCLES, exactly one internal one-cycle press pulse SHALL fire. No further pulse fires until btn has been 0 for at least one cycle.
REQ-023 In S_A, a press SHALL latch sw into opa and move to S_B. disp_src SHALL be 0 in S_A.
REQ-024 In S_B, a press SHALL latch sw into opb and op_sw into op_q, then move to S_EXEC. disp_src SHALL be 1 in S_B.
REQ-025 S_EXEC SHALL last exactly one cycle. At its closing edge the block SHALL capture res_q = {cy_in, res_in}, set res_valid = 1, and move to S_SHOW.
REQ-026 Presses arriving during S_EXEC SHALL be discarded, not queued.
REQ-027 In S_SHOW, disp_src SHALL be 2.
REQ-028 In S_SHOW, a press SHALL clear res_valid and move to S_A, leaving opa, opb and op_q unchanged.
REQ-029 clr = 1 SHALL force S_A on the next edge and zero opa, opb, op_q, res_q and res_valid. clr SHALL NOT affect the scan or debounce counters.
REQ-030 If clr and a press coincide, clr SHALL win and the press SHALL be dropped.
REQ-031 Scan: a counter SHALL count 0..SCAN_DIV-1 and wrap to 0. scan_sel SHALL toggle on each wrap, so it has a period of 2*SCAN_DIV cycles.
REQ-032 opa, opb and op_q SHALL change only on the latch events in REQ-023 and REQ-024, on clr, or on reset.

Reset
REQ-033 While rst_n = 0, the block SHALL hold state = S_A, opa = opb = 0, op_q = 0, res_q = 0 and res_valid = 0.
REQ-034 While rst_n = 0, the block SHALL also hold scan_sel = 0 (dis0 = 0, dis1 = 1), with the debounce counter, scan counter and release flag at 0.
REQ-035 Reset asserted mid-sequence, including during S_EXEC, SHALL abort it with no capture.

Verification
REQ-036 Add flow: sw = 7, press; sw = 5, op_sw = 0, press; datapath returns res_in = 2, cy_in = 1. Expect state sequence S_B, S_EXEC, S_SHOW; res_q = 5'b10010; res_valid = 1 exactly one cycle after entering S_EXEC.
REQ-037 Subtract flow: opa = 3, opb = 9, op_sw = 1. Expect op_q = 1 and res_q = {cy_in, res_in} as driven by the datapath model.
REQ-038 Debounce with DEB_CYCLES = 4:
- btn high for 3 cycles then low: no state change.
- btn high for 20 cycles: exactly one transition.
- 1-cycle glitches: ignored.
REQ-039 clr in S_B coincident with a debounced press: next state S_A, all operand and result registers 0.
REQ-040 Scan with SCAN_DIV = 4: after reset, scan_sel toggles every 4 cycles; dis0 and dis1 are always complementary.
REQ-041 rst_n pulsed low during S_EXEC: res_valid stays 0 and state returns to S_A asynchronously.
